frame_tx: RTL and testbench

Modbus RTU response frame transmitter for the slave datapath. Accepts one of three pre-assembled response vectors (exception, function-06 echo, function-03/04 read reply) from the CRC stage and serializes them byte by byte into `uart_byte_tx` via its `tx_start`/`tx_data`/`tx_done` handshake. Drives the RS-485 driver enable for the duration of the frame. Enforces a 3.5-character silent interval after each frame before another response is accepted.

---
 rtl/frame_tx_if.sv | 9 +
 rtl/frame_tx.sv | 135 +++++++++++++
 tb/tb_frame_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tx_if.sv
// Byte-level handshake between the frame transmitter and the UART byte transmitter.
interface frame_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (output tx_start, output tx_data, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/frame_tx.sv
// Modbus RTU response frame transmitter: serializes a pre-assembled response
// vector byte by byte into the UART and holds a 3.5-character silence afterwards.
module frame_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int GAP_CYCLES = ((CLK_FREQ / BAUD_RATE) * 385) / 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_exp_rp_start,
    input  logic         tx_06_rp_start,
    input  logic         tx_03_04_rp_start,
    input  logic [39:0]  exception_seq,
    input  logic [63:0]  code06_response,
    input  logic [103:0] code03_04_response,
    input  logic [7:0]   tx_quantity,
    frame_tx_if.master   uart,
    output logic         rs485_de,
    output logic         frame_busy,
    output logic         frame_done,
    output logic         tx_overrun,
    output logic         len_error
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state;
    logic [103:0]     shift_reg;
    logic [3:0]       byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             any_req;
    logic             qty_ok;

    assign any_req = tx_exp_rp_start | tx_06_rp_start | tx_03_04_rp_start;
    assign qty_ok  = (tx_quantity != 8'd0) && (tx_quantity <= 8'd4);

    assign uart.tx_start = tx_start;
    assign uart.tx_data  = tx_data;

    // byte_cnt holds the bytes still owed to the UART, including the one in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            rs485_de   <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            tx_overrun <= 1'b0;
            len_error  <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            tx_overrun <= 1'b0;
            len_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_exp_rp_start) begin
                        shift_reg  <= {exception_seq, 64'h0};
                        byte_cnt   <= 4'd5;
                        tx_data    <= exception_seq[39:32];
                        tx_start   <= 1'b1;
                        rs485_de   <= 1'b1;
                        frame_busy <= 1'b1;
                        state      <= SEND;
                    end else if (tx_06_rp_start) begin
                        shift_reg  <= {code06_response, 40'h0};
                        byte_cnt   <= 4'd8;
                        tx_data    <= code06_response[63:56];
                        tx_start   <= 1'b1;
                        rs485_de   <= 1'b1;
                        frame_busy <= 1'b1;
                        state      <= SEND;
                    end else if (tx_03_04_rp_start) begin
                        if (qty_ok) begin
                            shift_reg  <= code03_04_response;
                            byte_cnt   <= 4'd5 + {tx_quantity[2:0], 1'b0};
                            tx_data    <= code03_04_response[103:96];
                            tx_start   <= 1'b1;
                            rs485_de   <= 1'b1;
                            frame_busy <= 1'b1;
                            state      <= SEND;
                        end else begin
                            len_error <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (any_req) begin
                        tx_overrun <= 1'b1;
                    end
                    // a done arriving in the same cycle as our start belongs to an older byte
                    if (uart.tx_done && !tx_start) begin
                        if (byte_cnt == 4'd1) begin
                            rs485_de   <= 1'b0;
                            frame_done <= 1'b1;
                            byte_cnt   <= 4'd0;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else begin
                            shift_reg <= shift_reg << 8;
                            tx_data   <= shift_reg[95:88];
                            byte_cnt  <= byte_cnt - 4'd1;
                            tx_start  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (any_req) begin
                        tx_overrun <= 1'b1;
                    end
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt    <= '0;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// Directed self-checking bench for frame_tx with a stub UART that answers
// each tx_start with a tx_done ten clocks later.
module tb_frame_tx;

    // (2000000/115200)=17, 17*385/10 = 654 idle clocks
    localparam int GAP_EXP = 654;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_exp_rp_start;
    logic         tx_06_rp_start;
    logic         tx_03_04_rp_start;
    logic [39:0]  exception_seq;
    logic [63:0]  code06_response;
    logic [103:0] code03_04_response;
    logic [7:0]   tx_quantity;
    logic         rs485_de;
    logic         frame_busy;
    logic         frame_done;
    logic         tx_overrun;
    logic         len_error;

    int num_checks = 0;
    int num_errors = 0;

    logic [7:0] got[$];
    int start_cnt = 0;
    int de_cnt    = 0;
    int done_cnt  = 0;
    int ovr_cnt   = 0;
    int lerr_cnt  = 0;
    int gap_seen;

    frame_tx_if bus ();

    frame_tx #(
        .CLK_FREQ  (2000000),
        .BAUD_RATE (115200)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_exp_rp_start    (tx_exp_rp_start),
        .tx_06_rp_start     (tx_06_rp_start),
        .tx_03_04_rp_start  (tx_03_04_rp_start),
        .exception_seq      (exception_seq),
        .code06_response    (code06_response),
        .code03_04_response (code03_04_response),
        .tx_quantity        (tx_quantity),
        .uart               (bus),
        .rs485_de           (rs485_de),
        .frame_busy         (frame_busy),
        .frame_done         (frame_done),
        .tx_overrun         (tx_overrun),
        .len_error          (len_error)
    );

    always #5 clk = ~clk;

    // Stub UART: tx_done is raised nine negedges after tx_start is seen
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (bus.tx_start === 1'b1) begin
                repeat (9) @(negedge clk);
                bus.tx_done = 1'b1;
            end
        end
    end

    // Passive monitor of everything the DUT emits
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                got.push_back(bus.tx_data);
                start_cnt++;
            end
            if (rs485_de === 1'b1)   de_cnt++;
            if (frame_done === 1'b1) done_cnt++;
            if (tx_overrun === 1'b1) ovr_cnt++;
            if (len_error === 1'b1)  lerr_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        num_checks++;
        assert (obs === expv)
        else begin
            num_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic exp_r, input logic r06, input logic r0304);
        tx_exp_rp_start   = exp_r;
        tx_06_rp_start    = r06;
        tx_03_04_rp_start = r0304;
        @(negedge clk);
        tx_exp_rp_start   = 1'b0;
        tx_06_rp_start    = 1'b0;
        tx_03_04_rp_start = 1'b0;
    endtask

    task automatic clearMon();
        got.delete();
        start_cnt = 0;
        de_cnt    = 0;
        done_cnt  = 0;
        ovr_cnt   = 0;
        lerr_cnt  = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tx_start"}, {31'b0, bus.tx_start}, 32'd0);
        checkOutput({tag, "_tx_data"}, {24'b0, bus.tx_data}, 32'd0);
        checkOutput({tag, "_de"}, {31'b0, rs485_de}, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, frame_busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, frame_done}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'b0, tx_overrun}, 32'd0);
        checkOutput({tag, "_len_error"}, {31'b0, len_error}, 32'd0);
    endtask

    task automatic checkFirstByte(input string tag, input logic [7:0] b0);
        checkOutput({tag, "_start"}, {31'b0, bus.tx_start}, 32'd1);
        checkOutput({tag, "_byte0"}, {24'b0, bus.tx_data}, {24'b0, b0});
        checkOutput({tag, "_de"}, {31'b0, rs485_de}, 32'd1);
        checkOutput({tag, "_busy"}, {31'b0, frame_busy}, 32'd1);
    endtask

    task automatic waitFrame(input string tag);
        for (int i = 0; i < 400 && frame_done !== 1'b1; i++) @(negedge clk);
        checkOutput({tag, "_frame_done_seen"}, {31'b0, frame_done}, 32'd1);
        checkOutput({tag, "_de_low_at_done"}, {31'b0, rs485_de}, 32'd0);
    endtask

    task automatic waitIdle(output int cyc);
        cyc = 0;
        while (frame_busy === 1'b1 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic checkBytes(input string tag, input logic [103:0] expv, input int n);
        logic [7:0] g;
        checkOutput({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'b0, g}, {24'b0, expv[103-8*i -: 8]});
        end
    endtask

    task automatic runFrame(input string tag, input logic [103:0] expv, input int n);
        waitFrame(tag);
        waitIdle(gap_seen);
        checkOutput({tag, "_gap"}, gap_seen, GAP_EXP);
        checkBytes(tag, expv, n);
        checkOutput({tag, "_de_cycles"}, de_cnt, 10 * n);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_starts"}, start_cnt, n);
    endtask

    initial begin
        int n;
        rst                = 1'b1;
        tx_exp_rp_start    = 1'b0;
        tx_06_rp_start     = 1'b0;
        tx_03_04_rp_start  = 1'b0;
        exception_seq      = 40'h01_83_02_C0_F1;
        code06_response    = 64'h0106_0001_0003_980B;
        code03_04_response = '0;
        tx_quantity        = 8'd0;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] exception frame");
        clearMon();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkFirstByte("exc", 8'h01);
        runFrame("exc", {40'h01_83_02_C0_F1, 64'h0}, 5);

        $display("[TB] function 06 echo");
        clearMon();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkFirstByte("f06", 8'h01);
        runFrame("f06", {64'h0106_0001_0003_980B, 40'h0}, 8);

        $display("[TB] function 03 reply, quantity 1");
        clearMon();
        tx_quantity        = 8'd1;
        code03_04_response = 104'h01_03_02_04_51_CC_DD_00_00_00_00_00_00;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkFirstByte("f03", 8'h01);
        runFrame("f03", 104'h01_03_02_04_51_CC_DD_00_00_00_00_00_00, 7);

        $display("[TB] function 04 reply, quantity 4");
        clearMon();
        tx_quantity        = 8'd4;
        code03_04_response = 104'h01_04_08_00_0A_00_0B_00_0C_00_0D_E5_7F;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkFirstByte("f04", 8'h01);
        runFrame("f04", 104'h01_04_08_00_0A_00_0B_00_0C_00_0D_E5_7F, 13);

        $display("[TB] length errors");
        clearMon();
        tx_quantity = 8'd0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lenerr_q0_pulse", {31'b0, len_error}, 32'd1);
        checkOutput("lenerr_q0_no_start", {31'b0, bus.tx_start}, 32'd0);
        checkOutput("lenerr_q0_busy", {31'b0, frame_busy}, 32'd0);
        repeat (20) @(negedge clk);
        tx_quantity = 8'd5;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lenerr_q5_pulse", {31'b0, len_error}, 32'd1);
        checkOutput("lenerr_q5_no_start", {31'b0, bus.tx_start}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("lenerr_starts", start_cnt, 0);
        checkOutput("lenerr_pulses", lerr_cnt, 2);

        $display("[TB] collision exception vs 06");
        clearMon();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkFirstByte("coll", 8'h01);
        checkOutput("coll_no_overrun_now", {31'b0, tx_overrun}, 32'd0);
        runFrame("coll", {40'h01_83_02_C0_F1, 64'h0}, 5);
        checkOutput("coll_overruns", ovr_cnt, 0);

        $display("[TB] request during SEND");
        clearMon();
        tx_quantity = 8'd1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ovr_send_pulse", {31'b0, tx_overrun}, 32'd1);
        runFrame("ovr_send", {64'h0106_0001_0003_980B, 40'h0}, 8);
        checkOutput("ovr_send_count", ovr_cnt, 1);

        $display("[TB] request during GAP");
        clearMon();
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFrame("ovr_gap");
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovr_gap_pulse", {31'b0, tx_overrun}, 32'd1);
        checkOutput("ovr_gap_no_start", {31'b0, bus.tx_start}, 32'd0);
        waitIdle(gap_seen);
        checkOutput("ovr_gap_rest", gap_seen, GAP_EXP - 4);
        checkBytes("ovr_gap", {64'h0106_0001_0003_980B, 40'h0}, 8);
        checkOutput("ovr_gap_count", ovr_cnt, 1);
        checkOutput("ovr_gap_done_pulses", done_cnt, 1);

        $display("[TB] reset mid-frame");
        clearMon();
        applyStimulus(1'b0, 1'b1, 1'b0);
        n = 1;
        for (int i = 0; i < 100 && n < 3; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) n++;
        end
        checkOutput("rst_mid_third_start", {31'b0, bus.tx_start}, 32'd1);
        checkOutput("rst_mid_third_byte", {24'b0, bus.tx_data}, 32'h00);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("rst_mid");
        clearMon();
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("rst_mid_no_more_starts", start_cnt, 0);
        checkOutput("rst_mid_idle_busy", {31'b0, frame_busy}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkFirstByte("rst_after", 8'h01);
        runFrame("rst_after", {64'h0106_0001_0003_980B, 40'h0}, 8);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
